// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA read channel: cache-line geometry,
// channel state encoding and the counter/data typedefs.
package dma_pkg;

  localparam int CL_BYTES       = 64;
  localparam int CL_OFFSET_BITS = 6;

  localparam int DMA_SIZE_WIDTH = 43;
  localparam int DMA_DATA_WIDTH = 512;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } t_dma_rd_state;

  typedef logic [DMA_SIZE_WIDTH-1:0] count_t;
  typedef logic [DMA_DATA_WIDTH-1:0] cl_data_t;

endpackage

// File: rtl/dma_rd_fifo.sv
// Show-ahead response buffer: the head line is visible on o_rd_data whenever
// o_empty is low, and i_rd advances to the next line.
module dma_rd_fifo #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_wr,
  input  logic [DATA_WIDTH-1:0]        i_wr_data,
  input  logic                         i_rd,
  output logic [DATA_WIDTH-1:0]        o_rd_data,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic                         o_empty,
  output logic                         o_full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;
  logic                  w_wr;
  logic                  w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_count = r_count;
  assign w_wr    = i_wr & ~o_full;
  assign w_rd    = i_rd & ~o_empty;

  // NOTE: the storage array has no reset; the output is gated by o_empty instead,
  // which keeps the reset value at zero without a reset fan-out to every bit.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every block
  // sees the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/dma_rd_channel.sv
// DMA read channel: issues in-order cache-line reads under a credit limit that
// reserves FIFO space for every request, then hands lines to the consumer.
module dma_rd_channel
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = DMA_SIZE_WIDTH,
  parameter int DATA_WIDTH = DMA_DATA_WIDTH,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [SIZE_WIDTH-1:0] rd_size,
  input  logic                  rd_go,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  rd_done,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  rsp_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  t_dma_rd_state         r_state;
  t_dma_rd_state         w_state_next;
  logic [SIZE_WIDTH-1:0] r_size;
  logic [SIZE_WIDTH-1:0] r_issued;
  logic [SIZE_WIDTH-1:0] r_popped;
  logic [SIZE_WIDTH-1:0] r_outstanding;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic                  r_req_valid;
  logic                  r_rsp_err;

  logic                  w_req_valid_next;
  logic                  w_accept;
  logic                  w_rsp_ok;
  logic                  w_fifo_wr;
  logic                  w_pop;
  logic                  w_go;
  logic                  w_credit_ok;
  logic [SIZE_WIDTH-1:0] w_issued_next;
  logic [SIZE_WIDTH-1:0] w_popped_next;
  logic [SIZE_WIDTH-1:0] w_outstanding_next;
  logic [SIZE_WIDTH-1:0] w_fifo_count_next;
  logic [CNT_W-1:0]      w_fifo_count;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;

  dma_rd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr      (w_fifo_wr),
    .i_wr_data (mem_rsp_data),
    .i_rd      (w_pop),
    .o_rd_data (rd_data),
    .o_count   (w_fifo_count),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full)
  );

  assign w_accept  = r_req_valid & mem_req_ready;
  assign w_rsp_ok  = mem_rsp_valid & (r_outstanding != '0);
  assign w_fifo_wr = w_rsp_ok & ~w_fifo_full;
  assign w_pop     = rd_en & ~w_fifo_empty;
  assign w_go      = rd_go & ((r_state == IDLE) | (r_state == DONE));

  assign w_issued_next      = r_issued + SIZE_WIDTH'(w_accept);
  assign w_popped_next      = r_popped + SIZE_WIDTH'(w_pop);
  assign w_outstanding_next = r_outstanding + SIZE_WIDTH'(w_accept) - SIZE_WIDTH'(w_rsp_ok);
  assign w_fifo_count_next  = SIZE_WIDTH'(w_fifo_count) + SIZE_WIDTH'(w_fifo_wr)
                            - SIZE_WIDTH'(w_pop);

  // Post-edge occupancy must leave room for the request about to be raised.
  assign w_credit_ok = (w_outstanding_next + w_fifo_count_next) < SIZE_WIDTH'(FIFO_DEPTH);

  // NOTE: every combinational output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    w_state_next     = r_state;
    w_req_valid_next = r_req_valid & ~mem_req_ready;
    case (r_state)
      IDLE, DONE: begin
        if (w_go) begin
          w_state_next     = (rd_size == '0) ? DONE : ISSUE;
          w_req_valid_next = (rd_size != '0);
        end
      end
      ISSUE: begin
        if (!r_req_valid || mem_req_ready)
          w_req_valid_next = (w_issued_next < r_size) && w_credit_ok;
        if (w_accept && (w_issued_next == r_size)) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (w_popped_next == r_size) w_state_next = DONE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_size        <= '0;
      r_issued      <= '0;
      r_popped      <= '0;
      r_outstanding <= '0;
      r_req_addr    <= '0;
      r_req_valid   <= 1'b0;
      r_rsp_err     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_req_valid   <= w_req_valid_next;
      r_outstanding <= w_outstanding_next;
      if (w_go) begin
        r_size     <= rd_size;
        r_issued   <= '0;
        r_popped   <= '0;
        r_req_addr <= rd_addr & ~ADDR_WIDTH'(CL_BYTES - 1);
      end else begin
        r_issued <= w_issued_next;
        r_popped <= w_popped_next;
        if (w_accept) r_req_addr <= r_req_addr + ADDR_WIDTH'(CL_BYTES);
      end
      // A response with nothing outstanding has no slot reserved; drop and flag it.
      if (mem_rsp_valid && (r_outstanding == '0)) r_rsp_err <= 1'b1;
    end
  end

  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_req_addr;
  assign empty         = w_fifo_empty;
  assign rd_done       = (r_state == DONE);
  assign rsp_err       = r_rsp_err;

endmodule

// File: tb/tb_dma_rd_channel.sv
// Randomized bench for dma_rd_channel: a latency-modelled host memory, a
// transfer-level scoreboard and per-cycle protocol checks.
module tb_dma_rd_channel;
  import dma_pkg::*;

  localparam int AW    = 64;
  localparam int SW    = 43;
  localparam int DW    = 512;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rd_addr;
  logic [SW-1:0] rd_size;
  logic          rd_go;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          rd_done;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic          rsp_err;

  dma_rd_channel #(
    .ADDR_WIDTH (AW),
    .SIZE_WIDTH (SW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_addr       (rd_addr),
    .rd_size       (rd_size),
    .rd_go         (rd_go),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .empty         (empty),
    .rd_done       (rd_done),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .rsp_err       (rsp_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Stimulus policy knobs.
  int ready_pct  = 100;
  int pop_pct    = 100;
  int lat_lo     = 3;
  int lat_hi     = 3;
  int stall_left = 0;
  bit inject_stray = 1'b0;

  // Host memory: in-order queue of accepted requests with their due cycle.
  int            cyc = 0;
  int            last_due = 0;
  int            pend_due[$];
  logic [AW-1:0] pend_addr[$];

  // Transfer-level reference state.
  bit            m_active = 1'b0;
  bit            m_err = 1'b0;
  longint        m_size = 0;
  longint        n_req = 0;
  longint        n_pop = 0;
  int            m_avail = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [AW-1:0] exp_pop_addr = '0;
  logic [31:0]   salt = 32'h0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic cl_data_t line_of(input logic [AW-1:0] a);
    cl_data_t r;
    for (int i = 0; i < 8; i++) r[i*64 +: 64] = a ^ {salt, 32'(i)};
    return r;
  endfunction

  // One clock: drive inputs, predict the edge, then check registered outputs.
  task automatic cycle();
    bit            busy;
    bit            prev_valid;
    bit            prev_ready;
    logic [AW-1:0] prev_addr;
    int            due;

    if (stall_left > 0) begin
      mem_req_ready = 1'b0;
      stall_left--;
    end else begin
      mem_req_ready = ($urandom_range(99) < ready_pct);
    end
    rd_en         = ($urandom_range(99) < pop_pct);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = line_of(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
      m_avail++;
    end else if (inject_stray) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = {16{$urandom}};
      m_err         = 1'b1;
      inject_stray  = 1'b0;
    end

    busy = m_active && (n_pop < m_size);
    if (mem_req_valid && mem_req_ready) begin
      check("req_addr", DW'(mem_req_addr), DW'(exp_addr));
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_due.push_back(due);
      pend_addr.push_back(exp_addr);
      exp_addr += AW'(CL_BYTES);
      n_req++;
    end
    if (rd_en && !empty) begin
      check("rd_data", rd_data, line_of(exp_pop_addr));
      exp_pop_addr += AW'(CL_BYTES);
      n_pop++;
      m_avail--;
    end
    if (rd_go && !busy) begin
      m_active     = 1'b1;
      m_size       = longint'(rd_size);
      n_req        = 0;
      n_pop        = 0;
      exp_addr     = rd_addr & ~AW'(CL_BYTES - 1);
      exp_pop_addr = exp_addr;
      salt         = $urandom;
    end
    prev_valid = mem_req_valid;
    prev_ready = mem_req_ready;
    prev_addr  = mem_req_addr;

    @(posedge clk);
    @(negedge clk);
    cyc++;

    check("rd_done", DW'(rd_done), DW'(m_active && (n_pop == m_size)));
    check("empty", DW'(empty), DW'(m_avail == 0));
    check("rsp_err", DW'(rsp_err), DW'(m_err));
    if (prev_valid && !prev_ready)
      check("req_hold", DW'({mem_req_valid, mem_req_addr}), DW'({1'b1, prev_addr}));
    if (!m_active || n_req == m_size)
      check("req_idle", DW'(mem_req_valid), DW'(0));
    if (mem_req_valid)
      check("credit", DW'((n_req - n_pop + 1) <= DEPTH), DW'(1));
  endtask

  task automatic start(input logic [AW-1:0] a, input logic [SW-1:0] s);
    rd_addr = a;
    rd_size = s;
    rd_go   = 1'b1;
    cycle();
    rd_go   = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (!(m_active && n_pop == m_size) && n < budget) begin
      cycle();
      n++;
    end
    check("finish_done", DW'(rd_done), DW'(1));
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    rd_go         = 1'b0;
    rd_en         = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    #1;
    check("rst_req_valid", DW'(mem_req_valid), DW'(0));
    check("rst_req_addr", DW'(mem_req_addr), DW'(0));
    check("rst_empty", DW'(empty), DW'(1));
    check("rst_rd_done", DW'(rd_done), DW'(0));
    check("rst_rd_data", rd_data, '0);
    check("rst_rsp_err", DW'(rsp_err), DW'(0));
    pend_due.delete();
    pend_addr.delete();
    last_due = 0;
    m_active = 1'b0;
    m_err    = 1'b0;
    n_req    = 0;
    n_pop    = 0;
    m_avail  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rd_addr = '0;
    rd_size = '0;
    apply_reset();

    // Consumer pops into an idle channel: nothing changes.
    pop_pct = 100;
    repeat (3) cycle();

    // Basic transfer, fixed latency 3, consumer always ready.
    start(64'h1000, 43'd4);
    run_until_done(200);

    // Zero-length transfer completes without any request.
    start(64'h2000, 43'd0);
    repeat (4) cycle();

    // Backpressure: consumer stalled, only FIFO_DEPTH requests may issue.
    pop_pct = 0;
    lat_lo  = 2;
    lat_hi  = 4;
    start(64'h4_0000, 43'd40);
    repeat (80) cycle();
    check("bp_req_count", DW'(n_req), DW'(DEPTH));
    check("bp_valid_low", DW'(mem_req_valid), DW'(0));
    check("bp_lines_held", DW'(empty), DW'(0));
    pop_pct = 100;
    run_until_done(400);

    // Host stall mid-transfer with an unaligned start address.
    start(64'h1023, 43'd10);
    repeat (3) cycle();
    stall_left = 5;
    run_until_done(300);

    // A second go while issuing is ignored.
    ready_pct = 70;
    start(64'h8000, 43'd12);
    repeat (2) cycle();
    rd_addr = 64'h9_9900;
    rd_size = 43'd3;
    rd_go   = 1'b1;
    cycle();
    rd_go   = 1'b0;
    run_until_done(400);

    // Randomized transfers, one of them wrapping the top of the address space.
    for (int t = 0; t < 8; t++) begin
      ready_pct = $urandom_range(100, 40);
      pop_pct   = $urandom_range(100, 20);
      lat_lo    = $urandom_range(3, 1);
      lat_hi    = lat_lo + $urandom_range(4, 0);
      if (t == 3) start(64'hFFFF_FFFF_FFFF_FF80, 43'd5);
      else        start({$urandom, $urandom}, SW'($urandom_range(24, 1)));
      run_until_done(2000);
    end

    // Reset mid-transfer, then a stray response, then normal operation.
    ready_pct = 100;
    pop_pct   = 50;
    start(64'hA000, 43'd30);
    repeat (10) cycle();
    apply_reset();
    inject_stray = 1'b1;
    cycle();
    check("stray_err", DW'(rsp_err), DW'(1));
    pop_pct = 100;
    start(64'hB040, 43'd6);
    run_until_done(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
